// File: rtl/window_pkg.sv
// window_pkg: shared types, defaults and elaboration helpers for window_buffer
// and its line FIFOs.
package window_pkg;

  // Default pixel width; the modules take PIX_W as a parameter with this default.
  localparam int unsigned DefPixW = 4;

  typedef logic [DefPixW-1:0] pixel_t;

  // Window edge legality: only odd 3 or 5 are supported.
  function automatic bit k_is_legal(input int unsigned k);
    return (k == 3) || (k == 5);
  endfunction

  // Width of a coordinate counting 0..n-1, never narrower than one bit.
  function automatic int unsigned coord_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_buffer_if.sv
// window_buffer_if: pixel-in / window-out stream bundle for window_buffer.
// The slave modport is the window_buffer side; master is the stream source
// that also consumes the windows.
interface window_buffer_if #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned K     = 3
);
  import window_pkg::*;

  localparam int unsigned XW = coord_w(IMG_W);
  localparam int unsigned YW = coord_w(IMG_H);

  logic                   in_valid;
  logic                   in_sof;
  logic [PIX_W-1:0]       in_pixel;
  logic                   out_valid;
  logic [K*K*PIX_W-1:0]   out_window;
  logic [XW-1:0]          out_x;
  logic [YW-1:0]          out_y;
  logic                   err_frame;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_window, out_x, out_y, err_frame
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_window, out_x, out_y, err_frame
  );

endinterface

// File: rtl/line_fifo.sv
// line_fifo: fixed delay of DEPTH accepted samples. A circular RAM with one
// wrap-around pointer; the slot under the pointer is read out before it is
// overwritten, so o_data is the sample written DEPTH accepts ago.
module line_fifo
  import window_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned W     = DefPixW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  localparam int unsigned AW = coord_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  assign o_data = r_mem[r_ptr];

  // Pointer advances once per accepted sample and wraps at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_valid) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Line storage is deliberately not reset; stale lines are never emitted.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      r_mem[r_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/window_buffer.sv
// window_buffer: raster pixel stream in, K x K neighbourhood out, one window
// per accepted pixel once the window lies fully inside the image.
// Optional build macro WINDOW_FRAME_CHECK_EN adds the sticky err_frame check
// for short frames and missing start-of-frame; otherwise err_frame is 0.
module window_buffer
  import window_pkg::*;
#(
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned K     = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  window_buffer_if.slave bus
);

  localparam int unsigned XW = coord_w(IMG_W);
  localparam int unsigned YW = coord_w(IMG_H);
  localparam int unsigned WW = K * K * PIX_W;

  if (!k_is_legal(K)) begin : g_bad_k
    $error("window_buffer: K must be 3 or 5");
  end
  if ((IMG_W < K) || (IMG_H < K)) begin : g_bad_img
    $error("window_buffer: image must be at least K x K");
  end

  // Position counters: r_x/r_y hold where the next accepted pixel lands.
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x_cur;
  logic [YW-1:0] w_y_cur;
  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_emit;

  // Current pixel position (sof forces the origin) and the following one.
  always_comb begin
    w_x_cur    = bus.in_sof ? '0 : r_x;
    w_y_cur    = bus.in_sof ? '0 : r_y;
    w_last_col = (w_x_cur == XW'(IMG_W - 1));
    w_last_row = (w_y_cur == YW'(IMG_H - 1));
    w_x_nxt    = w_last_col ? '0 : w_x_cur + 1'b1;
    if (!w_last_col) begin
      w_y_nxt = w_y_cur;
    end else begin
      w_y_nxt = w_last_row ? '0 : w_y_cur + 1'b1;
    end
    w_emit = bus.in_valid && (w_x_cur >= XW'(K - 1)) && (w_y_cur >= YW'(K - 1));
  end

  // Counter state advances only on accepted pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (bus.in_valid) begin
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  // Chained line FIFOs: FIFO j yields the pixel j+1 lines above in this column.
  logic [PIX_W-1:0] w_fifo_in  [K-1];
  logic [PIX_W-1:0] w_fifo_out [K-1];

  for (genvar j = 0; j < K - 1; j++) begin : g_line
    if (j == 0) begin : g_head
      assign w_fifo_in[j] = bus.in_pixel;
    end else begin : g_chain
      assign w_fifo_in[j] = w_fifo_out[j-1];
    end

    line_fifo #(
      .DEPTH(IMG_W),
      .W    (PIX_W)
    ) u_line_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(bus.in_valid),
      .i_data (w_fifo_in[j]),
      .o_data (w_fifo_out[j])
    );
  end

  // Window array: row 0 is the oldest line, column 0 the oldest column.
  logic [PIX_W-1:0] r_win     [K][K];
  logic [PIX_W-1:0] w_win_nxt [K][K];
  logic [WW-1:0]    w_win_flat;

  // Shift every row left and load the new right column from FIFOs + input.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_win_nxt[r][c] = r_win[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      w_win_nxt[r][K-1] = w_fifo_out[K-2-r];
    end
    w_win_nxt[K-1][K-1] = bus.in_pixel;
  end

  // Flatten the updated array into the tap (r,c) bit layout.
  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win_flat[(r*K+c)*PIX_W +: PIX_W] = w_win_nxt[r][c];
      end
    end
  end

  // Window registers update on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (bus.in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= w_win_nxt[r][c];
        end
      end
    end
  end

  // Registered outputs: pulse valid, hold payload between emissions.
  logic            r_out_valid;
  logic [WW-1:0]   r_out_window;
  logic [XW-1:0]   r_out_x;
  logic [YW-1:0]   r_out_y;

  // One-cycle emission of the completed window and its top-left coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_window <= w_win_flat;
        r_out_x      <= w_x_cur - XW'(K - 1);
        r_out_y      <= w_y_cur - YW'(K - 1);
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_window = r_out_window;
  assign bus.out_x      = r_out_x;
  assign bus.out_y      = r_out_y;

`ifdef WINDOW_FRAME_CHECK_EN
  logic r_sof_seen;
  logic r_wrapped;
  logic r_err;

  // Sticky frame check: sof before the frame end, or a wrap with no sof after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sof_seen <= 1'b0;
      r_wrapped  <= 1'b0;
      r_err      <= 1'b0;
    end else if (bus.in_valid) begin
      if (bus.in_sof) begin
        r_sof_seen <= 1'b1;
      end
      r_wrapped <= w_last_col && w_last_row;
      if ((bus.in_sof && r_sof_seen && !r_wrapped) || (!bus.in_sof && r_wrapped)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.err_frame = r_err;
`else
  assign bus.err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_window_buffer.sv
// tb_window_buffer: directed bench for window_buffer with K=3, 8x6 image,
// 4-bit pixels valued (y*8+x) mod 16.
`timescale 1ns/1ps
module tb_window_buffer;

  localparam int unsigned PW = 4;
  localparam int unsigned IW = 8;
  localparam int unsigned IH = 6;
  localparam int unsigned KK = 3;
  localparam int unsigned WW = KK * KK * PW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  window_buffer_if #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH), .K(KK)) u_if ();

  window_buffer #(
    .PIX_W(PW),
    .IMG_W(IW),
    .IMG_H(IH),
    .K    (KK)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  bit exp_err = 1'b0;
  // Expected {out_x, out_y, out_window} of the most recent emission.
  logic [3+3+WW-1:0] last_exp = '0;

  always @(negedge clk) begin
    if (u_if.out_valid === 1'b1) n_pulse++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] pixv(input int x, input int y);
    return 4'((y * 8 + x) % 16);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int x0, input int y0);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[(r*3+c)*4 +: 4] = pixv(x0 + c, y0 + r);
      end
    end
    return w;
  endfunction

  // Drive one cycle of input and return at the following negedge.
  task automatic step(input bit v, input bit sof, input logic [3:0] pix);
    u_if.in_valid = v;
    u_if.in_sof   = sof;
    u_if.in_pixel = pix;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (u_if.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_valid: got %b want 0", u_if.out_valid); end
    n_cmp++; if (u_if.out_window !== '0) begin n_bad++;
      $display("FAIL reset_window: got %h want 0", u_if.out_window); end
    n_cmp++; if (u_if.out_x !== 3'd0) begin n_bad++;
      $display("FAIL reset_x: got %0d want 0", u_if.out_x); end
    n_cmp++; if (u_if.out_y !== 3'd0) begin n_bad++;
      $display("FAIL reset_y: got %0d want 0", u_if.out_y); end
    n_cmp++; if (u_if.err_frame !== 1'b0) begin n_bad++;
      $display("FAIL reset_err: got %b want 0", u_if.err_frame); end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_frame();
    bit exp_v;
    n_pulse = 0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        step(1'b1, (x == 0 && y == 0), pixv(x, y));
        exp_v = (x >= 2 && y >= 2);
        if (exp_v) last_exp = {3'(x - 2), 3'(y - 2), exp_win(x - 2, y - 2)};
        n_cmp++;
        if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
          n_bad++;
          $display("FAIL frame px(%0d,%0d): got v=%b x=%0d y=%0d w=%h want v=%b w=%h",
                   x, y, u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window,
                   exp_v, last_exp[WW-1:0]);
        end
        if (x == 2 && y == 2) begin
          n_cmp++; if (u_if.out_window[3:0] !== 4'd0) begin n_bad++;
            $display("FAIL first_tap00: got %0d want 0", u_if.out_window[3:0]); end
          n_cmp++; if (u_if.out_window[35:32] !== 4'd2) begin n_bad++;
            $display("FAIL first_tap22: got %0d want 2", u_if.out_window[35:32]); end
          n_cmp++; if (u_if.out_window[19:16] !== 4'd9) begin n_bad++;
            $display("FAIL first_tap11: got %0d want 9", u_if.out_window[19:16]); end
        end
        if (x == 2 && y == 3) begin
          n_cmp++;
          if ({u_if.out_x, u_if.out_y, u_if.out_window[3:0]} !== {3'd0, 3'd1, 4'd8}) begin
            n_bad++;
            $display("FAIL row_boundary: got x=%0d y=%0d tap00=%0d want x=0 y=1 tap00=8",
                     u_if.out_x, u_if.out_y, u_if.out_window[3:0]);
          end
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++; if (n_pulse != 24) begin n_bad++;
      $display("FAIL frame_count: got %0d want 24", n_pulse); end
    n_cmp++; if (u_if.err_frame !== 1'b0) begin n_bad++;
      $display("FAIL frame_err: got %b want 0", u_if.err_frame); end
  endtask

  task automatic test_gaps();
    bit exp_v;
    n_pulse = 0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        repeat ($urandom_range(0, 1)) begin
          step(1'b0, 1'b0, 4'hf);
          n_cmp++;
          if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {1'b0, last_exp}) begin
            n_bad++;
            $display("FAIL gap_idle before px(%0d,%0d): got v=%b x=%0d y=%0d want v=0 held",
                     x, y, u_if.out_valid, u_if.out_x, u_if.out_y);
          end
        end
        step(1'b1, (x == 0 && y == 0), pixv(x, y));
        exp_v = (x >= 2 && y >= 2);
        if (exp_v) last_exp = {3'(x - 2), 3'(y - 2), exp_win(x - 2, y - 2)};
        n_cmp++;
        if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
          n_bad++;
          $display("FAIL gap px(%0d,%0d): got v=%b x=%0d y=%0d w=%h want v=%b w=%h",
                   x, y, u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window,
                   exp_v, last_exp[WW-1:0]);
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++; if (n_pulse != 24) begin n_bad++;
      $display("FAIL gap_count: got %0d want 24", n_pulse); end
  endtask

  task automatic test_two_frames();
    bit exp_v;
    n_pulse = 0;
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < 6; y++) begin
        for (int x = 0; x < 8; x++) begin
          step(1'b1, (f == 0 && x == 0 && y == 0), pixv(x, y));
          exp_v = (x >= 2 && y >= 2);
          if (exp_v) last_exp = {3'(x - 2), 3'(y - 2), exp_win(x - 2, y - 2)};
          n_cmp++;
          if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
            n_bad++;
            $display("FAIL two_frames f%0d px(%0d,%0d): got v=%b x=%0d y=%0d want v=%b",
                     f, x, y, u_if.out_valid, u_if.out_x, u_if.out_y, exp_v);
          end
          if (f == 1 && x == 0 && y == 0) begin
`ifdef WINDOW_FRAME_CHECK_EN
            exp_err = 1'b1;
`endif
            n_cmp++; if (u_if.err_frame !== exp_err) begin n_bad++;
              $display("FAIL nosof_err: got %b want %b", u_if.err_frame, exp_err); end
          end
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++; if (n_pulse != 48) begin n_bad++;
      $display("FAIL two_frames_count: got %0d want 48", n_pulse); end
  endtask

  task automatic test_mid_sof();
    bit exp_v;
    n_pulse = 0;
    // Partial frame ends at (4,3); the next pixel carries sof.
    for (int p = 0; p < 29; p++) begin
      step(1'b1, (p == 0), pixv(p % 8, p / 8));
      exp_v = ((p % 8) >= 2 && (p / 8) >= 2);
      if (exp_v) last_exp = {3'((p % 8) - 2), 3'((p / 8) - 2), exp_win((p % 8) - 2, (p / 8) - 2)};
      n_cmp++;
      if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
        n_bad++;
        $display("FAIL mid_sof_pre p=%0d: got v=%b x=%0d y=%0d want v=%b",
                 p, u_if.out_valid, u_if.out_x, u_if.out_y, exp_v);
      end
    end
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        step(1'b1, (x == 0 && y == 0), pixv(x, y));
        exp_v = (x >= 2 && y >= 2);
        if (exp_v) last_exp = {3'(x - 2), 3'(y - 2), exp_win(x - 2, y - 2)};
        n_cmp++;
        if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
          n_bad++;
          $display("FAIL mid_sof px(%0d,%0d): got v=%b x=%0d y=%0d want v=%b",
                   x, y, u_if.out_valid, u_if.out_x, u_if.out_y, exp_v);
        end
        if (x == 0 && y == 0) begin
`ifdef WINDOW_FRAME_CHECK_EN
          exp_err = 1'b1;
`endif
          n_cmp++; if (u_if.err_frame !== exp_err) begin n_bad++;
            $display("FAIL mid_sof_err: got %b want %b", u_if.err_frame, exp_err); end
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++; if (n_pulse != 33) begin n_bad++;
      $display("FAIL mid_sof_count: got %0d want 33", n_pulse); end
  endtask

  task automatic test_reset_mid();
    bit exp_v;
    for (int p = 0; p < 36; p++) begin
      step(1'b1, (p == 0), pixv(p % 8, p / 8));
    end
    // Reset asserted while pixel (4,4) is presented.
    u_if.in_valid = 1'b1;
    u_if.in_sof   = 1'b0;
    u_if.in_pixel = pixv(4, 4);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window, u_if.err_frame} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outs: got v=%b x=%0d y=%0d w=%h e=%b want all 0",
               u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window, u_if.err_frame);
    end
    @(negedge clk);
    step(1'b1, 1'b0, pixv(5, 4));
    n_cmp++;
    if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window, u_if.err_frame} !== '0) begin
      n_bad++;
      $display("FAIL midreset_hold: got v=%b x=%0d y=%0d e=%b want all 0",
               u_if.out_valid, u_if.out_x, u_if.out_y, u_if.err_frame);
    end
    exp_err  = 1'b0;
    last_exp = '0;
    u_if.in_valid = 1'b0;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    n_pulse = 0;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        step(1'b1, (x == 0 && y == 0), pixv(x, y));
        exp_v = (x >= 2 && y >= 2);
        if (exp_v) last_exp = {3'(x - 2), 3'(y - 2), exp_win(x - 2, y - 2)};
        n_cmp++;
        if ({u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window} !== {exp_v, last_exp}) begin
          n_bad++;
          $display("FAIL after_reset px(%0d,%0d): got v=%b x=%0d y=%0d w=%h want v=%b w=%h",
                   x, y, u_if.out_valid, u_if.out_x, u_if.out_y, u_if.out_window,
                   exp_v, last_exp[WW-1:0]);
        end
      end
    end
    step(1'b0, 1'b0, 4'h0);
    n_cmp++; if (n_pulse != 24) begin n_bad++;
      $display("FAIL after_reset_count: got %0d want 24", n_pulse); end
    n_cmp++; if (u_if.err_frame !== 1'b0) begin n_bad++;
      $display("FAIL after_reset_err: got %b want 0", u_if.err_frame); end
  endtask

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_sof   = 1'b0;
    u_if.in_pixel = '0;
    test_reset();
    test_frame();
    test_gaps();
    test_two_frames();
    test_mid_sof();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
# window_buffer

Parametrised sliding-window generator for the edge-detection pipeline. It accepts a raster-order pixel stream with a valid qualifier and stores K−1 previous lines in line FIFOs. Once a full K×K neighbourhood is in-image, it emits that neighbourhood every accepted pixel, tagged with its frame coordinates. It sits between the frame-buffer reader and the Sobel/convolution kernels and replaces the fixed 3×3, 640-wide shift-register tap.

## Interface
- PIX_W, 4, bits per pixel
- IMG_W, 640, pixels per line (≥ K)
- IMG_H, 480, lines per frame (≥ K)
- K, 3, window edge; odd, 3 or 5 only (elaboration error otherwise)

- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  pixel present this cycle
- in_sof  input  1  start of frame; qualified by in_valid
- in_pixel  input  PIX_W  pixel data
- out_valid  output  1  out_window/out_x/out_y valid this cycle
- out_window  output  K*K*PIX_W  tap (r,c) at bits [(r*K+c)*PIX_W +: PIX_W]; r=0 top (oldest line), c=0 left (oldest column)
- out_x  output  $clog2(IMG_W)  column of window top-left
- out_y  output  $clog2(IMG_H)  line of window top-left
- err_frame  output  1  sticky frame-length error (see Configuration)

## Operation
- Input counters x_in, y_in give the position of the current accepted pixel. They advance only on in_valid; idle gaps are arbitrary.
- in_valid && in_sof: the pixel is (0,0) and counters restart from there. in_sof without in_valid is ignored.
- Wrap: x_in = IMG_W−1 → x_in = 0, y_in + 1. At (IMG_W−1, IMG_H−1), the next pixel is (0,0) even without in_sof.
- Line storage: K−1 line FIFOs chained, each IMG_W deep. On each accepted pixel, FIFO j outputs the pixel from the same column j+1 lines earlier.
- Window registers: a K×K array. On accept, every row shifts left one column. The new right column is {FIFO K−2 out, …, FIFO 0 out, in_pixel} for rows 0..K−1.
- Emission: when the accepted pixel satisfies x_in ≥ K−1 and y_in ≥ K−1, out_valid pulses on the next cycle with:
  - out_x = x_in−K+1
  - out_y = y_in−K+1
  - out_window = the updated array
- Only full in-image windows are emitted. No padding. Count per frame = (IMG_W−K+1)·(IMG_H−K+1).
- Line FIFO contents are not reset. Windows from lines y < K−1 are suppressed, so stale data never reaches the output.
- No backpressure. Downstream must accept one window per accepted input.

## Timing
- Reset values: out_valid=0, out_window=0, out_x=0, out_y=0, err_frame=0, x_in=y_in=0, window array=0.
- Latency: exactly 1 cycle from an accepted qualifying pixel to out_valid. The output is fully registered.
- Throughput: one pixel per cycle sustained.
- out_* hold their value while out_valid=0.
- Reset mid-frame: the counters restart at (0,0). The first window after reset requires K−1 complete lines plus K pixels.
- in_sof mid-frame: takes effect on that pixel. A pending out_valid from the previous cycle is still delivered.

## Configuration
- WINDOW_FRAME_CHECK_EN defined:
  - err_frame sets when in_valid && in_sof arrives and the previous frame has not reached (IMG_W−1, IMG_H−1).
  - err_frame also sets when the wrap at (IMG_W−1, IMG_H−1) is followed by a pixel without in_sof.
  - The first in_sof after reset never sets it. It stays set until rst_n.
- Not defined: err_frame is tied 0 and no check logic is built. Datapath behaviour is identical in both cases.

## Structure
- Package window_pkg holds:
  - the pixel typedef parametrised via PIX_W defaults
  - the K legality check constant
  - the coordinate-width helper functions
- Sub-module line_fifo (parameters DEPTH=IMG_W, W=PIX_W):
  - circular RAM with a single wrap-around pointer
  - read-before-write on in_valid, giving a fixed delay of DEPTH accepted samples
  - K−1 instances

## Test plan
Bench parameters: K=3, IMG_W=8, IMG_H=6, PIX_W=4. Pixel value = (y·8+x) mod 16.
- One continuous frame with sof at (0,0) → first out_valid one cycle after input (2,2), with out_x=0, out_y=0, tap(0,0)=0, tap(2,2)=2, tap(1,1)=9. Exactly 24 out_valid pulses in the frame, no error.
- Same frame with in_valid low on random cycles (~50%) → identical window sequence and coordinates. out_valid is never asserted without a preceding accept.
- Row boundary → no out_valid for inputs x=0,1 of any line. Input (2,3) yields out_x=0, out_y=1, tap(0,0)=8.
- Two frames with no sof on the second → wraps to (0,0). The second frame reproduces the same 24 windows.
  - With WINDOW_FRAME_CHECK_EN, err_frame=1 after the first pixel of frame 2; without the macro it stays 0.
- in_sof at input (5,3) followed by a full frame → counters restart and the next window is (0,0), emitted after input (2,2).
  - With WINDOW_FRAME_CHECK_EN, err_frame=1 from the cycle after that in_sof.
- rst_n low at input (4,4), then a new frame → all outputs 0 during reset, no out_valid until the new (2,2), and the window contents are correct.
